// File: rtl/rlwe_pkg.sv
// Shared constants and types for the RLWE core front end.
package rlwe_pkg;
  localparam int WIDTH      = 64;
  localparam int MAX_SIZE   = 1024;
  localparam int ADDR_WIDTH = $clog2(MAX_SIZE);

  localparam int          OPC_W       = 6;
  localparam int          OPC_MSB     = WIDTH - 1;
  localparam int          OPC_LSB     = WIDTH - OPC_W;
  localparam logic [5:0]  OPCODE_HALT = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/rlwe_fetch_buf.sv
// Two-entry synchronous FIFO holding {addr, data} of returned instruction words.
module rlwe_fetch_buf #(
  parameter int DW = 74
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_count
);
  logic [1:0][DW-1:0] r_mem;
  logic               r_wr;
  logic               r_rd;
  logic [1:0]         r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_clear) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/rlwe_ifetch.sv
// Instruction fetch: streams words from the instruction SRAM to the decoder until HALT.
module rlwe_ifetch #(
  parameter int WIDTH      = rlwe_pkg::WIDTH,
  parameter int MAX_SIZE   = rlwe_pkg::MAX_SIZE,
  parameter int ADDR_WIDTH = $clog2(MAX_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [WIDTH-1:0]      read_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [WIDTH-1:0]      instr_data,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  busy,
  output logic                  done
);
  import rlwe_pkg::*;

  localparam int EW = ADDR_WIDTH + WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_LAST = ADDR_WIDTH'(MAX_SIZE - 1);

  fetch_state_e          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_fly;
  logic [ADDR_WIDTH-1:0] r_fly_addr;

  logic [1:0]            w_cnt;
  logic [EW-1:0]         w_head;
  logic                  w_start_ok, w_ret, w_ret_halt, w_head_halt;
  logic                  w_bypass, w_push, w_pop, w_issue, w_occ_ok;

  assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
  // A return is only live while running; anything landing in DRAIN/DONE trails HALT.
  assign w_ret       = r_fly && (r_state == RUN);
  assign w_ret_halt  = read_data[WIDTH-1 -: 6] == OPCODE_HALT;
  assign w_head_halt = w_head[WIDTH-1 -: 6] == OPCODE_HALT;
  assign w_bypass    = w_ret && (w_cnt == 2'd0);
  assign w_pop       = (w_cnt != 2'd0) && instr_ready;
  assign w_push      = w_ret && !(w_bypass && instr_ready);
  assign w_occ_ok    = ({1'b0, w_cnt} + {2'b00, r_fly}) < 3'd2;
  assign w_issue     = (r_state == RUN) && (r_pc != wr_ptr) && w_occ_ok;

  rlwe_fetch_buf #(.DW(EW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start_ok),
    .i_push  (w_push),
    .i_data  ({r_fly_addr, read_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_state_nxt = RUN;
      RUN:        if (w_ret && w_ret_halt)
                    w_state_nxt = (w_bypass && instr_ready) ? DONE : DRAIN;
      DRAIN:      if (w_pop && w_head_halt) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_fly      <= 1'b0;
      r_fly_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fly   <= w_issue;
      if (w_issue) r_fly_addr <= r_pc;
      if (w_start_ok)   r_pc <= '0;
      else if (w_issue) r_pc <= (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
    end
  end

  always_comb begin
    instr_valid = 1'b0;
    instr_data  = '0;
    instr_addr  = '0;
    if (w_cnt != 2'd0) begin
      instr_valid = 1'b1;
      {instr_addr, instr_data} = w_head;
    end else if (w_ret) begin
      instr_valid = 1'b1;
      instr_data  = read_data;
      instr_addr  = r_fly_addr;
    end
  end

  assign read_en   = w_issue;
  assign read_addr = r_pc;
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
endmodule
